// File: rtl/wb_commit_arbiter.sv
// Writeback commit arbiter: buffers ALU/MUL/MEM results in per-source FIFOs and
// retires one entry per cycle to the register file with round-robin priority.
module wb_commit_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_wb_writereg,
  input  logic [ADDR_W-1:0] alu_wb_regdest,
  input  logic [DATA_W-1:0] alu_wb_wbvalue,
  input  logic              mul_wb_writereg,
  input  logic [ADDR_W-1:0] mul_wb_regdest,
  input  logic [DATA_W-1:0] mul_wb_wbvalue,
  input  logic              mem_wb_writereg,
  input  logic [ADDR_W-1:0] mem_wb_regdest,
  input  logic [DATA_W-1:0] mem_wb_wbvalue,
  output logic              wb_alu_full,
  output logic              wb_mul_full,
  output logic              wb_mem_full,
  output logic              wb_rf_we,
  output logic [ADDR_W-1:0] wb_rf_addr,
  output logic [DATA_W-1:0] wb_rf_data,
  output logic              wb_iss_release,
  output logic [ADDR_W-1:0] wb_iss_regdest,
  output logic              wb_overflow
);
  localparam int NSRC  = 3;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [1:0] SRC_MEM = 2'd2;

  logic [NSRC-1:0]  push_req;
  logic [ENT_W-1:0] push_ent [NSRC];
  logic [ENT_W-1:0] head     [NSRC];
  logic [NSRC-1:0]  full;
  logic [NSRC-1:0]  nonempty;
  logic [NSRC-1:0]  pop;

  assign push_req    = {mem_wb_writereg, mul_wb_writereg, alu_wb_writereg};
  assign push_ent[0] = {alu_wb_regdest, alu_wb_wbvalue};
  assign push_ent[1] = {mul_wb_regdest, mul_wb_wbvalue};
  assign push_ent[2] = {mem_wb_regdest, mem_wb_wbvalue};

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_fifo
      logic [ENT_W-1:0] store_reg [DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [PTR_W-1:0] rd_ptr_reg;
      logic [CNT_W-1:0] count_reg;
      logic             push_ok;

      // A push into a full FIFO is dropped even when that FIFO pops this edge.
      assign full[gi]     = (count_reg == CNT_W'(DEPTH));
      assign nonempty[gi] = (count_reg != '0);
      assign push_ok      = push_req[gi] && !full[gi];
      // Head is read asynchronously so the arbiter can pick and pop in one cycle.
      assign head[gi]     = store_reg[rd_ptr_reg];

      always_ff @(posedge clock) begin
        if (push_ok) begin
          store_reg[wr_ptr_reg] <= push_ent[gi];
        end
      end

      always_ff @(posedge clock) begin
        if (!reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({push_ok, pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  logic [1:0]        rr_reg;
  logic [1:0]        win;
  logic [1:0]        cand;
  logic              found;
  logic [ENT_W-1:0]  win_ent;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Search starts at the source after the last winner and wraps around.
  always_comb begin
    pop   = '0;
    win   = rr_reg;
    cand  = rr_reg;
    found = 1'b0;
    for (int k = 1; k <= NSRC; k++) begin
      cand = 2'((32'(rr_reg) + 32'(k)) % NSRC);
      if (!found && nonempty[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (found) pop[win] = 1'b1;
  end

  assign win_ent  = head[win];
  assign win_addr = win_ent[ENT_W-1:DATA_W];
  assign win_data = win_ent[DATA_W-1:0];

  logic              rf_we_reg;
  logic [ADDR_W-1:0] rf_addr_reg;
  logic [DATA_W-1:0] rf_data_reg;
  logic              release_reg;
  logic [ADDR_W-1:0] rel_dest_reg;
  logic              overflow_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_reg       <= SRC_MEM;
      rf_we_reg    <= 1'b0;
      rf_addr_reg  <= '0;
      rf_data_reg  <= '0;
      release_reg  <= 1'b0;
      rel_dest_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      // r0 is never written, but its scoreboard slot must still be released.
      rf_we_reg   <= found && (win_addr != '0);
      release_reg <= found;
      if (found) begin
        rr_reg       <= win;
        rf_addr_reg  <= win_addr;
        rf_data_reg  <= win_data;
        rel_dest_reg <= win_addr;
      end
      if (|(push_req & full)) overflow_reg <= 1'b1;
    end
  end

  assign wb_alu_full    = full[0];
  assign wb_mul_full    = full[1];
  assign wb_mem_full    = full[2];
  assign wb_rf_we       = rf_we_reg;
  assign wb_rf_addr     = rf_addr_reg;
  assign wb_rf_data     = rf_data_reg;
  assign wb_iss_release = release_reg;
  assign wb_iss_regdest = rel_dest_reg;
  assign wb_overflow    = overflow_reg;
endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Bench for wb_commit_arbiter: queue-based reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_wb_commit_arbiter;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              alu_v = 1'b0, mul_v = 1'b0, mem_v = 1'b0;
  logic [ADDR_W-1:0] alu_rd = '0, mul_rd = '0, mem_rd = '0;
  logic [DATA_W-1:0] alu_d = '0, mul_d = '0, mem_d = '0;
  logic              wb_alu_full, wb_mul_full, wb_mem_full;
  logic              wb_rf_we, wb_iss_release, wb_overflow;
  logic [ADDR_W-1:0] wb_rf_addr, wb_iss_regdest;
  logic [DATA_W-1:0] wb_rf_data;

  wb_commit_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .alu_wb_writereg(alu_v), .alu_wb_regdest(alu_rd), .alu_wb_wbvalue(alu_d),
    .mul_wb_writereg(mul_v), .mul_wb_regdest(mul_rd), .mul_wb_wbvalue(mul_d),
    .mem_wb_writereg(mem_v), .mem_wb_regdest(mem_rd), .mem_wb_wbvalue(mem_d),
    .wb_alu_full(wb_alu_full), .wb_mul_full(wb_mul_full), .wb_mem_full(wb_mem_full),
    .wb_rf_we(wb_rf_we), .wb_rf_addr(wb_rf_addr), .wb_rf_data(wb_rf_data),
    .wb_iss_release(wb_iss_release), .wb_iss_regdest(wb_iss_regdest),
    .wb_overflow(wb_overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: one queue per source, last-winner index, output copies.
  logic [ADDR_W+DATA_W-1:0] q [3][$];
  int                m_rr = 2;
  logic              m_we = 0, m_rel = 0, m_ovf = 0;
  logic [ADDR_W-1:0] m_addr = '0, m_rdest = '0;
  logic [DATA_W-1:0] m_data = '0;

  int alu_writes = 0;
  bit seen_full  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] v,
                       input logic [ADDR_W-1:0] ra, input logic [DATA_W-1:0] da,
                       input logic [ADDR_W-1:0] rm, input logic [DATA_W-1:0] dm,
                       input logic [ADDR_W-1:0] re, input logic [DATA_W-1:0] de);
    alu_v = v[0]; mul_v = v[1]; mem_v = v[2];
    alu_rd = ra; alu_d = da; mul_rd = rm; mul_d = dm; mem_rd = re; mem_d = de;
  endtask

  task automatic idle();
    drive(3'b000, '0, '0, '0, '0, '0, '0);
  endtask

  // Advance the model by one edge from the current inputs, clock the DUT, compare.
  task automatic step();
    logic [2:0]               pv;
    logic [ADDR_W+DATA_W-1:0] pe [3];
    logic [ADDR_W+DATA_W-1:0] ent;
    bit   [2:0]               full_pre;
    int                       win;
    pv = {mem_v, mul_v, alu_v};
    pe[0] = {alu_rd, alu_d}; pe[1] = {mul_rd, mul_d}; pe[2] = {mem_rd, mem_d};
    if (!reset) begin
      for (int s = 0; s < 3; s++) q[s].delete();
      m_rr = 2; m_we = 0; m_rel = 0; m_ovf = 0;
      m_addr = '0; m_rdest = '0; m_data = '0;
    end else begin
      for (int s = 0; s < 3; s++) full_pre[s] = (q[s].size() == DEPTH);
      win = -1;
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_rr + k) % 3;
        if (win < 0 && q[c].size() > 0) win = c;
      end
      if (win >= 0) begin
        ent     = q[win].pop_front();
        m_rr    = win;
        m_addr  = ent[ADDR_W+DATA_W-1:DATA_W];
        m_data  = ent[DATA_W-1:0];
        m_rdest = m_addr;
        m_rel   = 1;
        m_we    = (m_addr != 0);
      end else begin
        m_rel = 0;
        m_we  = 0;
      end
      for (int s = 0; s < 3; s++) begin
        if (pv[s]) begin
          if (full_pre[s]) m_ovf = 1;
          else q[s].push_back(pe[s]);
        end
      end
    end
    @(posedge clock);
    #1;
    chk("rf_we",       64'(wb_rf_we),       64'(m_we));
    chk("iss_release", 64'(wb_iss_release), 64'(m_rel));
    chk("rf_addr",     64'(wb_rf_addr),     64'(m_addr));
    chk("rf_data",     64'(wb_rf_data),     64'(m_data));
    chk("iss_regdest", 64'(wb_iss_regdest), 64'(m_rdest));
    chk("overflow",    64'(wb_overflow),    64'(m_ovf));
    chk("alu_full",    64'(wb_alu_full),    64'(q[0].size() == DEPTH));
    chk("mul_full",    64'(wb_mul_full),    64'(q[1].size() == DEPTH));
    chk("mem_full",    64'(wb_mem_full),    64'(q[2].size() == DEPTH));
    if (wb_rf_we && wb_rf_data[31:28] == 4'hA) alu_writes++;
    if (wb_alu_full) seen_full = 1;
    $display("t=%0t rst=%b push=%b%b%b we=%b addr=%0d data=%h rel=%b rd=%0d ovf=%b",
             $time, reset, mem_v, mul_v, alu_v, wb_rf_we, wb_rf_addr, wb_rf_data,
             wb_iss_release, wb_iss_regdest, wb_overflow);
  endtask

  task automatic apply_reset();
    idle();
    reset = 0; step(); step();
    reset = 1;
  endtask

  initial begin
    // Reset, then idle: everything quiet.
    apply_reset();
    for (int i = 0; i < 5; i++) step();
    chk("idle_we", 64'(wb_rf_we), 64'd0);
    chk("idle_rel", 64'(wb_iss_release), 64'd0);
    chk("idle_full", 64'({wb_alu_full, wb_mul_full, wb_mem_full}), 64'd0);
    chk("idle_ovf", 64'(wb_overflow), 64'd0);

    // Single MEM push retires two edges later.
    drive(3'b100, '0, '0, '0, '0, 5'd3, 32'hDEADBEEF);
    step(); idle();
    chk("mem1_we_early", 64'(wb_rf_we), 64'd0);
    step();
    chk("mem1_we", 64'(wb_rf_we), 64'd1);
    chk("mem1_addr", 64'(wb_rf_addr), 64'd3);
    chk("mem1_data", 64'(wb_rf_data), 64'hDEADBEEF);
    chk("mem1_rel", 64'(wb_iss_release), 64'd1);
    step();
    chk("mem1_we_after", 64'(wb_rf_we), 64'd0);

    // Simultaneous push from reset: ALU, MUL, MEM order.
    apply_reset();
    drive(3'b111, 5'd1, 32'h11, 5'd2, 32'h22, 5'd4, 32'h44);
    step(); idle();
    step(); chk("rr_first", 64'(wb_rf_addr), 64'd1);
    step(); chk("rr_second", 64'(wb_rf_addr), 64'd2);
    step(); chk("rr_third", 64'(wb_rf_addr), 64'd4);
    step(); chk("rr_done", 64'(wb_rf_we), 64'd0);

    // Saturating burst on all three: ALU fills, overflows, 7 ALU pushes accepted.
    apply_reset();
    alu_writes = 0; seen_full = 0;
    for (int i = 0; i < 10; i++) begin
      drive(3'b111, 5'(i + 1), 32'hA000_0000 + 32'(i), 5'(i + 11), 32'hB000_0000 + 32'(i),
            5'(i + 21), 32'hC000_0000 + 32'(i));
      step();
    end
    idle();
    chk("burst_alu_full_seen", 64'(seen_full), 64'd1);
    chk("burst_ovf", 64'(wb_overflow), 64'd1);
    for (int i = 0; i < 20; i++) step();
    chk("burst_alu_writes", 64'(alu_writes), 64'd7);

    // Reset with three entries buffered discards them and clears overflow.
    drive(3'b111, 5'd5, 32'h5, 5'd6, 32'h6, 5'd7, 32'h7);
    step(); idle();
    reset = 0; step(); reset = 1;
    chk("rst_ovf", 64'(wb_overflow), 64'd0);
    chk("rst_full", 64'({wb_alu_full, wb_mul_full, wb_mem_full}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(); chk("rst_no_write", 64'({wb_rf_we, wb_iss_release}), 64'd0);
    end
    drive(3'b100, '0, '0, '0, '0, 5'd9, 32'h1234);
    step(); idle();
    chk("fresh_early", 64'(wb_rf_we), 64'd0);
    step();
    chk("fresh_we", 64'(wb_rf_we), 64'd1);
    chk("fresh_addr", 64'(wb_rf_addr), 64'd9);

    // regdest 0: released but not written.
    drive(3'b001, 5'd0, 32'h55, '0, '0, '0, '0);
    step(); idle(); step();
    chk("r0_we", 64'(wb_rf_we), 64'd0);
    chk("r0_rel", 64'(wb_iss_release), 64'd1);
    chk("r0_regdest", 64'(wb_iss_regdest), 64'd0);
    step();

    // Randomized traffic with varying load and occasional reset.
    for (int seg = 0; seg < 4; seg++) begin
      int p;
      p = (seg == 0) ? 20 : (seg == 1) ? 50 : (seg == 2) ? 90 : 65;
      for (int i = 0; i < 100; i++) begin
        drive({$urandom_range(0, 99) < p, $urandom_range(0, 99) < p, $urandom_range(0, 99) < p},
              5'($urandom), $urandom, 5'($urandom), $urandom, 5'($urandom), $urandom);
        reset = ($urandom_range(0, 59) != 0);
        step();
      end
    end
    reset = 1; idle();
    for (int i = 0; i < 15; i++) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
